// File: rtl/ps2_rx_receptor.sv
// ps2_rx_receptor: PS/2 keyboard serial receiver.
//   Synchronises and glitch-filters the keyboard clock/data lines, deframes
//   11-bit frames (start, 8 data LSB-first, odd parity, stop) and presents
//   each valid scancode with a one-cycle rx_done_tick.
// Ports:
//   clk          - system clock
//   reset        - asynchronous active-high reset
//   ps2c, ps2d   - raw PS/2 clock / data lines (asynchronous)
//   rx_en        - receive enable, gates only the start of a new frame
//   dout         - last valid scancode byte
//   rx_done_tick - one-cycle pulse when dout updates
//   parity_err   - one-cycle pulse: frame complete, parity not odd
//   frame_err    - one-cycle pulse: bad start/stop bit or inter-edge timeout
module ps2_rx_receptor #(
    parameter int unsigned FILTER_LEN  = 8,
    parameter int unsigned TIMEOUT_CYC = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2c,
    input  logic       ps2d,
    input  logic       rx_en,
    output logic [7:0] dout,
    output logic       rx_done_tick,
    output logic       parity_err,
    output logic       frame_err
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYC);
    // Compare one short so the error pulse is visible in the cycle the
    // counter would reach TIMEOUT_CYC-1.
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 2);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        LOAD
    } state_t;

    // Input conditioning
    logic                  c_s1_q, c_s2_q, d_s1_q, d_s2_q;
    logic [FILTER_LEN-1:0] filt_q;
    logic                  lvl_q, lvl_d;
    logic                  fall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            c_s1_q <= 1'b1;
            c_s2_q <= 1'b1;
            d_s1_q <= 1'b1;
            d_s2_q <= 1'b1;
            filt_q <= '1;
            lvl_q  <= 1'b1;
        end else begin
            c_s1_q <= ps2c;
            c_s2_q <= c_s1_q;
            d_s1_q <= ps2d;
            d_s2_q <= d_s1_q;
            filt_q <= {filt_q[FILTER_LEN-2:0], c_s2_q};
            lvl_q  <= lvl_d;
        end
    end

    always_comb begin
        lvl_d = lvl_q;
        if (&filt_q)
            lvl_d = 1'b1;
        else if (~|filt_q)
            lvl_d = 1'b0;
    end

    assign fall = lvl_q & ~lvl_d;

    // Deframer
    state_t          state_q, state_d;
    logic [3:0]      bits_q, bits_d;
    logic [9:0]      sh_q, sh_d;
    logic [TW-1:0]   to_q, to_d;
    logic [7:0]      dout_q, dout_d;
    logic            done_q, done_d;
    logic            perr_q, perr_d;
    logic            ferr_q, ferr_d;
    logic [10:0]     frame;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            bits_q  <= '0;
            sh_q    <= '0;
            to_q    <= '0;
            dout_q  <= '0;
            done_q  <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bits_q  <= bits_d;
            sh_q    <= sh_d;
            to_q    <= to_d;
            dout_q  <= dout_d;
            done_q  <= done_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
        end
    end

    // The frame register keeps the first ten bits; the eleventh (stop) bit is
    // appended combinationally so the frame is judged on the stop-bit fall and
    // the registered result pulses during the single LOAD cycle.
    always_comb begin
        state_d = state_q;
        bits_d  = bits_q;
        sh_d    = sh_q;
        to_d    = '0;
        dout_d  = dout_q;
        done_d  = 1'b0;
        perr_d  = 1'b0;
        ferr_d  = 1'b0;
        frame   = {d_s2_q, sh_q};

        case (state_q)
            IDLE: begin
                if (fall && rx_en) begin
                    sh_d    = frame[10:1];
                    bits_d  = 4'd10;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (fall) begin
                    sh_d   = frame[10:1];
                    bits_d = bits_q - 4'd1;
                    if (bits_q == 4'd1) begin
                        state_d = LOAD;
                        if (frame[0] || !frame[10])
                            ferr_d = 1'b1;
                        else if (!(^frame[9:1]))
                            perr_d = 1'b1;
                        else begin
                            done_d = 1'b1;
                            dout_d = frame[8:1];
                        end
                    end
                end else if (to_q == TO_LAST) begin
                    ferr_d  = 1'b1;
                    sh_d    = '0;
                    state_d = IDLE;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
            LOAD: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign dout         = dout_q;
    assign rx_done_tick = done_q;
    assign parity_err   = perr_q;
    assign frame_err    = ferr_q;

endmodule

// File: tb/tb_ps2_rx_receptor.sv
module tb_ps2_rx_receptor;

    localparam int L = 8;
    localparam int T = 200;
    localparam int H = 25;   // PS/2 half period in clk cycles

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ps2c = 1'b1;
    logic       ps2d = 1'b1;
    logic       rx_en = 1'b1;
    logic [7:0] dout;
    logic       rx_done_tick, parity_err, frame_err;

    always #5 clk = ~clk;

    ps2_rx_receptor #(.FILTER_LEN(L), .TIMEOUT_CYC(T)) dut (
        .clk(clk), .reset(reset), .ps2c(ps2c), .ps2d(ps2d), .rx_en(rx_en),
        .dout(dout), .rx_done_tick(rx_done_tick),
        .parity_err(parity_err), .frame_err(frame_err)
    );

    typedef struct {
        int         kind;   // 0 done, 1 parity error, 2 frame error
        logic [7:0] data;
    } ev_t;

    ev_t        q[$];
    int         errors = 0;
    int         checks = 0;
    logic [7:0] exp_dout = 8'h00;
    int         n_done = 0;
    int         exp_done = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [10:0] f, input int n, input int drop_at);
        for (int i = 0; i < n; i++) begin
            if (i == drop_at) rx_en = 1'b0;
            ps2d = f[i];
            wait_cyc(H);
            ps2c = 1'b0;
            wait_cyc(H);
            ps2c = 1'b1;
        end
    endtask

    // err: 0 good, 1 parity flipped, 2 bad stop, 3 bad start
    function automatic logic [10:0] build(input logic [7:0] b, input int err);
        logic par, start, stop;
        par   = ($countones(b) % 2 == 0) ? 1'b1 : 1'b0;
        start = 1'b0;
        stop  = 1'b1;
        if (err == 1) par = ~par;
        if (err == 2) stop = 1'b0;
        if (err == 3) start = 1'b1;
        return {stop, par, b, start};
    endfunction

    task automatic expect_frame(input logic [10:0] f);
        ev_t e;
        e.data = f[8:1];
        if (f[0] !== 1'b0 || f[10] !== 1'b1) e.kind = 2;
        else if ($countones(f[9:1]) % 2 == 0) e.kind = 1;
        else begin
            e.kind = 0;
            exp_done++;
        end
        q.push_back(e);
    endtask

    task automatic send_frame(input logic [7:0] b, input int err, input int drop_at);
        logic [10:0] f;
        f = build(b, err);
        expect_frame(f);
        send_bits(f, 11, drop_at);
    endtask

    // Monitor: any output pulse pops one expected event
    always @(negedge clk) begin
        ev_t e;
        int  k;
        if (rx_done_tick | parity_err | frame_err) begin
            chk("one_pulse", $countones({rx_done_tick, parity_err, frame_err}), 1);
            if (rx_done_tick) n_done++;
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: done=%0b perr=%0b ferr=%0b with nothing expected",
                         rx_done_tick, parity_err, frame_err);
            end else begin
                e = q.pop_front();
                k = rx_done_tick ? 0 : (parity_err ? 1 : 2);
                chk("pulse_kind", k, e.kind);
                if (e.kind == 0) exp_dout = e.data;
                chk("dout", {24'h0, dout}, {24'h0, exp_dout});
            end
        end
    end

    initial begin : main
        int cnt;
        logic [10:0] f;

        wait_cyc(5);
        @(negedge clk);
        chk("rst_dout", dout, 8'h00);
        chk("rst_done", rx_done_tick, 0);
        chk("rst_perr", parity_err, 0);
        chk("rst_ferr", frame_err, 0);
        reset = 1'b0;
        wait_cyc(5);

        send_frame(8'h1C, 0, -1);
        send_frame(8'hF0, 0, -1);
        send_frame(8'h21, 0, -1);
        send_frame(8'h1C, 1, -1);
        wait_cyc(10);

        // short low glitch on the clock line must be filtered out
        ps2c = 1'b0;
        wait_cyc(3);
        ps2c = 1'b1;
        wait_cyc(20);
        send_frame(8'h5A, 0, -1);
        wait_cyc(10);

        // timeout after 5 bits
        f = build(8'h33, 0);
        send_bits(f, 4, -1);
        begin
            ev_t e;
            e.kind = 2;
            e.data = 8'h00;
            q.push_back(e);
        end
        ps2d = f[4];
        wait_cyc(H);
        ps2c = 1'b0;
        cnt = 0;
        while (cnt < 1000) begin
            @(posedge clk);
            cnt++;
            @(negedge clk);
            if (cnt == H) ps2c = 1'b1;
            if (frame_err) break;
        end
        ps2c = 1'b1;
        chk("timeout_latency", cnt, 2 + L + T);
        wait_cyc(10);
        send_frame(8'h75, 0, -1);
        wait_cyc(10);

        // reset after 6 bits
        f = build(8'h44, 0);
        send_bits(f, 6, -1);
        reset = 1'b1;
        wait_cyc(3);
        @(negedge clk);
        chk("midrst_dout", dout, 8'h00);
        chk("midrst_done", rx_done_tick, 0);
        chk("midrst_perr", parity_err, 0);
        chk("midrst_ferr", frame_err, 0);
        exp_dout = 8'h00;
        #1 reset = 1'b0;
        wait_cyc(5);
        send_frame(8'h6B, 0, -1);

        // disabled receiver ignores a whole frame
        rx_en = 1'b0;
        send_bits(build(8'h99, 0), 11, -1);
        rx_en = 1'b1;
        wait_cyc(10);

        // enable dropped mid-frame: frame still completes
        send_frame(8'hA5, 0, 3);
        rx_en = 1'b1;
        send_frame(8'h12, 2, -1);
        send_frame(8'h34, 3, -1);

        for (int i = 0; i < 12; i++) begin
            int r, err;
            r = $urandom_range(0, 9);
            err = (r < 2) ? 1 : (r == 2) ? 2 : (r == 3) ? 3 : 0;
            send_frame(8'($urandom_range(0, 255)), err, -1);
            wait_cyc($urandom_range(0, 3));
        end

        wait_cyc(40);
        chk("queue_empty", q.size(), 0);
        chk("done_count", n_done, exp_done);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ps2_rx_receptor.md
Name: ps2_rx_receptor

Overview:
PS/2 keyboard serial receiver sitting directly upstream of the key-decode stage.
- Synchronises and glitch-filters the keyboard clock and data lines.
- Deframes 11-bit PS/2 frames: start, 8 data bits LSB-first, odd parity, stop.
- Presents each valid scancode byte with a one-cycle rx_done_tick, which the decoder consumes as CodigoTecla_salida/rx_done_tick.
- Flags parity, framing and timeout errors without emitting a tick.

Parameters:
- FILTER_LEN, 8, number of consecutive equal synchronised ps2c samples needed to change the filtered clock level (min 2).
- TIMEOUT_CYC, 100000, clk cycles allowed between falling edges inside a frame before the frame is abandoned (2 ms at 50 MHz).

Ports:
- clk, input, 1, system clock.
- reset, input, 1, asynchronous active-high reset.
- ps2c, input, 1, raw PS/2 clock line (asynchronous).
- ps2d, input, 1, raw PS/2 data line (asynchronous).
- rx_en, input, 1, receive enable; gates only the start of new frames.
- dout, output, 8, last valid scancode byte.
- rx_done_tick, output, 1, one-cycle pulse when dout updates with a valid frame.
- parity_err, output, 1, one-cycle pulse: frame complete but parity not odd.
- frame_err, output, 1, one-cycle pulse: bad start/stop bit, or timeout.

Behaviour:
Reset values (asynchronous; all registers):
- dout=8'h00, rx_done_tick=0, parity_err=0, frame_err=0.
- Filtered clock level = 1; state = IDLE; bit counter = 0; timeout counter = 0.

Input conditioning:
- ps2c and ps2d each pass through a 2-FF synchroniser (sync FFs reset to 1).
- Synchronised ps2c shifts into a FILTER_LEN-bit register every clk.
- Filtered level becomes 1 when all bits are 1, becomes 0 when all bits are 0, otherwise holds.
- fall = previous filtered level 1 AND new filtered level 0; lasts one cycle.
- ps2d is sampled (synchronised value) in the cycle fall is high.
- Pulses shorter than FILTER_LEN cycles on ps2c never generate fall.

State machine (IDLE, DATA, LOAD):
- IDLE: on fall with rx_en=1, go to DATA and load the bit counter with 10.
  - Start-bit value is captured into bit 0 of an 11-bit shift register; sampled bits shift in from the MSB.
  - fall with rx_en=0 is ignored.
- DATA: on each fall, shift ps2d in and decrement the counter.
  - A fall seen with counter=1 is the stop bit: go to LOAD.
- LOAD (one cycle): evaluate the captured frame s[10:0], where s[0]=start, s[8:1]=data, s[9]=parity, s[10]=stop.
  - s[0]=0, s[10]=1, and XOR of s[9:1]=1 → dout<=s[8:1] and rx_done_tick=1.
  - Start/stop wrong → frame_err=1; dout unchanged.
  - Start/stop correct but parity even → parity_err=1; dout unchanged.
  - Framing is checked first: at most one of the three pulses fires per frame.
  - Always return to IDLE.
- Latency: the output pulse is high in the cycle after the cycle in which the 11th fall is detected. dout holds its value until the next valid frame.

Timeout:
- In DATA the timeout counter increments every clk and clears on each fall.
- Reaching TIMEOUT_CYC-1 → frame_err pulse, go to IDLE, shift register discarded.
- Counter width is clog2(TIMEOUT_CYC); the counter is held at 0 outside DATA.

Boundary conditions:
- rx_en deasserted mid-frame: the frame completes normally.
- fall arriving in the LOAD cycle: impossible when FILTER_LEN ≥ 2; if it occurs anyway it is ignored.
- Reset mid-frame: immediate return to IDLE; no pulse on any output.
- Back-to-back frames: the first fall after LOAD starts the next frame. No byte loss for consecutive frames such as F0 followed by 21.

Test Plan:
- Send frame for 8'h1C (data LSB-first, parity 0, stop 1) with a 40 µs PS/2 clock period → one rx_done_tick, dout=8'h1C, no error pulses.
- Send 8'hF0 (parity 1) then 8'h21 (parity 1) back-to-back → two rx_done_ticks, dout=8'hF0 then 8'h21, exactly 2 pulses total.
- Send 8'h1C with parity bit 1 → parity_err pulses once, rx_done_tick stays 0, dout keeps its previous value.
- Insert a 3-cycle low glitch on ps2c in IDLE (FILTER_LEN=8), then a valid 8'h5A frame → the glitch produces no state change; dout=8'h5A.
- Send 5 bits of a frame, then stop toggling ps2c → frame_err pulses exactly TIMEOUT_CYC cycles after the last fall; a following valid 8'h75 frame yields dout=8'h75.
- Assert reset after the 6th bit of a frame, release it, then send 8'h6B → no pulses during reset; all outputs return to reset values; dout=8'h6B with one rx_done_tick.
